// File: rtl/led_drv_pkg.sv
// rtl/led_drv_pkg.sv - shared mode encodings and helpers for the LED status driver
package led_drv_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  // Channel index width, never below one bit so a single-channel build still has a port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_status_driver_if.sv
// rtl/led_status_driver_if.sv - config write port, event inputs and LED outputs
interface led_status_driver_if
  import led_drv_pkg::*;
#(
  parameter int NUM_CH = 10,
  parameter int PWM_W  = 8
);

  localparam int CH_W = ch_width(NUM_CH);

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [MODE_W-1:0] cfg_mode;
  logic [PWM_W-1:0]  cfg_arg;
  logic [NUM_CH-1:0] events;
  logic [NUM_CH-1:0] led;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_arg, events, input led);
  modport slave  (input cfg_we, cfg_ch, cfg_mode, cfg_arg, events, output led);

endinterface

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: mode/arg registers, output mux, optional event stretch
// Optional feature: LED_EVENT_STRETCH_EN adds a per-channel event stretch counter.
module led_channel
  import led_drv_pkg::*;
#(
  parameter int         CNT_W       = 24,
  parameter int         PWM_W       = 8,
  parameter int         STRETCH_CYC = 2500000,
  parameter mode_e      RST_MODE    = MODE_OFF,
  parameter logic [PWM_W-1:0] RST_ARG = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [MODE_W-1:0] mode_in,
  input  logic [PWM_W-1:0]  arg_in,
  input  logic              evt,
  input  logic [CNT_W-1:0]  cnt,
  output logic              led
);

  mode_e            mode_q;
  logic [PWM_W-1:0] arg_q;
  logic [PWM_W-1:0] arg_wr;
  logic             mode_bit;
  logic             force_on;

  // Blink taps beyond the counter are clamped so the stored arg always names a real bit.
  always_comb begin
    arg_wr = arg_in;
    if (mode_e'(mode_in) == MODE_BLINK && int'(arg_in) > CNT_W - 1) begin
      arg_wr = PWM_W'(CNT_W - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= RST_MODE;
      arg_q  <= RST_ARG;
    end else if (we) begin
      mode_q <= mode_e'(mode_in);
      arg_q  <= arg_wr;
    end
  end

  always_comb begin
    mode_bit = 1'b0;
    case (mode_q)
      MODE_ON:    mode_bit = 1'b1;
      MODE_BLINK: mode_bit = |(cnt & (CNT_W'(1) << arg_q));
      MODE_PWM:   mode_bit = cnt[PWM_W-1:0] < arg_q;
      default:    mode_bit = 1'b0;
    endcase
  end

`ifdef LED_EVENT_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYC + 1);

  logic [SW-1:0] stretch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stretch <= '0;
    end else if (evt) begin
      stretch <= SW'(STRETCH_CYC);
    end else if (stretch != '0) begin
      stretch <= stretch - SW'(1);
    end
  end

  assign force_on = (stretch != '0);
`else
  wire unused_evt = evt;

  assign force_on = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      led <= force_on | mode_bit;
    end
  end

endmodule

// File: rtl/led_status_driver.sv
// rtl/led_status_driver.sv - multi-channel LED driver sharing one free-running prescale counter
// Optional feature: LED_EVENT_STRETCH_EN enables per-channel event stretching.
module led_status_driver
  import led_drv_pkg::*;
#(
  parameter int NUM_CH      = 10,
  parameter int CNT_W       = 24,
  parameter int PWM_W       = 8,
  parameter int STRETCH_CYC = 2500000
) (
  input logic                CLOCK_50,
  input logic                reset_n,
  led_status_driver_if.slave bus
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] led_w;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Top channel resets to blinking at the counter MSB, matching the legacy heartbeat.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam bit IS_TOP = (i == NUM_CH - 1);

    led_channel #(
      .CNT_W       (CNT_W),
      .PWM_W       (PWM_W),
      .STRETCH_CYC (STRETCH_CYC),
      .RST_MODE    (IS_TOP ? MODE_BLINK : MODE_OFF),
      .RST_ARG     (IS_TOP ? PWM_W'(CNT_W - 1) : PWM_W'(0))
    ) u_ch (
      .clk     (CLOCK_50),
      .rst_n   (reset_n),
      .we      (bus.cfg_we && (bus.cfg_ch == CH_W'(i))),
      .mode_in (bus.cfg_mode),
      .arg_in  (bus.cfg_arg),
      .evt     (bus.events[i]),
      .cnt     (cnt),
      .led     (led_w[i])
    );
  end

  assign bus.led = led_w;

endmodule
